// File: rtl/sample_stream_packetizer.sv
// rtl/sample_stream_packetizer.sv - FWFT-buffered sample stream packetizer with tlast framing
// Optional SAMPLE_DROP_EN: the sampler is never stalled; samples offered while full are dropped and counted.
module sample_stream_packetizer #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int PKT_LEN_W  = 16
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          enable,
    input  logic [PKT_LEN_W-1:0]          pkt_len,
    input  logic [DATA_W-1:0]             s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [DATA_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
`ifdef SAMPLE_DROP_EN
    ,
    output logic [15:0]                   drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [AW:0]          level;
    logic                 run;
    logic                 full;
    logic                 empty;
    logic                 s_hs;
    logic                 push;
    logic                 pop;
    logic                 last;
    logic [PKT_LEN_W-1:0] beat_cnt;
    logic [PKT_LEN_W-1:0] cur_len;
    logic [PKT_LEN_W-1:0] eff_len;

    assign full  = (level == (AW+1)'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign s_hs  = s_axis_tvalid & s_axis_tready;

    // run holds tready low until the first clock edge after reset release
`ifdef SAMPLE_DROP_EN
    assign s_axis_tready = run & enable;
    assign push          = s_hs & ~full;
`else
    assign s_axis_tready = run & enable & ~full;
    assign push          = s_hs;
`endif

    assign m_axis_tvalid = ~empty;
    assign m_axis_tdata  = empty ? '0 : mem[rd_ptr];
    assign pop           = m_axis_tvalid & m_axis_tready;
    assign fifo_level    = level;

    // At a packet start the live pkt_len is used so beat 0 already frames correctly
    assign eff_len      = (beat_cnt == '0) ? pkt_len : cur_len;
    assign last         = (eff_len <= PKT_LEN_W'(1)) || (beat_cnt == eff_len - PKT_LEN_W'(1));
    assign m_axis_tlast = m_axis_tvalid & last;

    always_ff @(posedge ACLK) begin
        if (push) begin
            mem[wr_ptr] <= s_axis_tdata;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            run      <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
            cur_len  <= '0;
        end else begin
            run <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (beat_cnt == '0) begin
                cur_len <= pkt_len;
            end
            if (pop) begin
                beat_cnt <= last ? '0 : beat_cnt + 1'b1;
            end
        end
    end

`ifdef SAMPLE_DROP_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            drop_cnt <= '0;
        end else if (s_hs && full && drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_stream_packetizer.sv
// tb/tb_sample_stream_packetizer.sv - directed self-checking bench for sample_stream_packetizer
module tb_sample_stream_packetizer;
    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] pkt_len = 16'd4;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [4:0]  fifo_level;
`ifdef SAMPLE_DROP_EN
    logic [15:0] drop_cnt;
`endif

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          first_in;
    int          first_out;
    int          n_acc;
    logic [31:0] in_q[$];
    logic [31:0] out_d[$];
    logic        out_l[$];

    sample_stream_packetizer #(
        .DATA_W(32),
        .FIFO_DEPTH(16),
        .PKT_LEN_W(16)
    ) dut (
        .ACLK(ACLK),
        .ARESET(ARESET),
        .enable(enable),
        .pkt_len(pkt_len),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .fifo_level(fifo_level)
`ifdef SAMPLE_DROP_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic set_in();
        s_axis_tvalid = (in_q.size() > 0);
        s_axis_tdata  = (in_q.size() > 0) ? in_q[0] : '0;
    endtask

    // Observe handshakes just before the rising edge, then re-drive at the falling edge
    task automatic tick();
        #1;
        if (m_axis_tvalid && m_axis_tready) begin
            out_d.push_back(m_axis_tdata);
            out_l.push_back(m_axis_tlast);
            if (first_out < 0) first_out = cyc;
        end
        if (s_axis_tvalid && s_axis_tready) begin
            void'(in_q.pop_front());
            if (first_in < 0) first_in = cyc;
            n_acc++;
        end
        @(posedge ACLK);
        cyc++;
        @(negedge ACLK);
        set_in();
    endtask

    task automatic clear_obs();
        out_d.delete();
        out_l.delete();
        first_in  = -1;
        first_out = -1;
        n_acc     = 0;
    endtask

    task automatic load(input logic [31:0] first_val, input int n);
        for (int i = 0; i < n; i++) in_q.push_back(first_val + 32'(i));
        set_in();
    endtask

    task automatic run_out(input string tag, input int n_out, input int max_cyc,
                           input int chg_at, input logic [15:0] chg_len);
        for (int c = 0; c < max_cyc && out_d.size() < n_out; c++) begin
            if (chg_at >= 0 && out_d.size() == chg_at) pkt_len = chg_len;
            tick();
        end
        check({tag, "_beats"}, out_d.size(), n_out);
    endtask

    task automatic check_beats(input string tag, input int n, input logic [31:0] first_val,
                               input logic [31:0] last_mask);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), (i < out_d.size()) ? out_d[i] : 32'hDEAD_BEEF,
                  first_val + 32'(i));
            check($sformatf("%s_last%0d", tag, i), (i < out_l.size()) ? out_l[i] : 1'bx,
                  last_mask[i]);
        end
    endtask

    initial begin
        clear_obs();
        enable        = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h77;
        repeat (2) @(negedge ACLK);
        #1;
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_level", fifo_level, 0);
`ifdef SAMPLE_DROP_EN
        check("rst_drop", drop_cnt, 0);
`endif
        s_axis_tvalid = 1'b0;
        @(negedge ACLK);
        ARESET = 1'b0;
        #1;
        check("rel_tready_early", s_axis_tready, 0);
        @(posedge ACLK);
        #1;
        check("rel_tready_after_edge", s_axis_tready, 1);
        @(negedge ACLK);

        // Basic framing and one-cycle latency
        clear_obs();
        pkt_len = 16'd4;
        m_axis_tready = 1'b1;
        load(32'h1, 8);
        run_out("p4", 8, 40, -1, 16'd0);
        check("p4_latency", first_out - first_in, 1);
        check_beats("p4", 8, 32'h1, 32'b1000_1000);

        // Lengths 0 and 1 both give single-beat packets
        clear_obs();
        pkt_len = 16'd0;
        load(32'h11, 3);
        run_out("len0", 3, 20, -1, 16'd0);
        pkt_len = 16'd1;
        load(32'h14, 3);
        run_out("len1", 6, 20, -1, 16'd0);
        check_beats("len01", 6, 32'h11, 32'b11_1111);

        // Length changed 4 -> 2 after beat 2: current packet still ends at beat 4
        clear_obs();
        pkt_len = 16'd4;
        load(32'h21, 8);
        run_out("chg", 8, 40, 2, 16'd2);
        check_beats("chg", 8, 32'h21, 32'b1010_1000);

        // enable low: no acceptance, buffer still drains, beat count held
        clear_obs();
        pkt_len = 16'd4;
        m_axis_tready = 1'b0;
        load(32'h31, 2);
        repeat (2) tick();
        enable = 1'b0;
        load(32'h33, 2);
        #1;
        check("dis_tready", s_axis_tready, 0);
        m_axis_tready = 1'b1;
        repeat (4) tick();
        check("dis_drained", out_d.size(), 2);
        check("dis_acc", n_acc, 2);
        check("dis_level", fifo_level, 0);
        enable = 1'b1;
        run_out("dis", 4, 20, -1, 16'd0);
        check_beats("dis", 4, 32'h31, 32'b1000);

        // 20 samples against a stalled output
        clear_obs();
        pkt_len = 16'd4;
        m_axis_tready = 1'b0;
        load(32'h1, 20);
        repeat (20) tick();
        #1;
        check("bp_level", fifo_level, 16);
`ifdef SAMPLE_DROP_EN
        check("bp_drop", drop_cnt, 4);
        check("bp_acc", n_acc, 20);
        check("bp_tready", s_axis_tready, 1);
        m_axis_tready = 1'b1;
        run_out("bp", 16, 60, -1, 16'd0);
        repeat (3) tick();
        check("bp_no_extra", out_d.size(), 16);
        check_beats("bp", 16, 32'h1, 32'h8888);
`else
        check("bp_tready", s_axis_tready, 0);
        check("bp_acc", n_acc, 16);
        m_axis_tready = 1'b1;
        run_out("bp", 20, 80, -1, 16'd0);
        check_beats("bp", 20, 32'h1, 32'h8_8888);
`endif

        // Reset mid-packet with 5 samples buffered
        clear_obs();
        pkt_len = 16'd4;
        m_axis_tready = 1'b1;
        load(32'h51, 2);
        run_out("pre", 2, 20, -1, 16'd0);
        m_axis_tready = 1'b0;
        load(32'h61, 5);
        repeat (5) tick();
        check("pre_level", fifo_level, 5);
        ARESET = 1'b1;
        in_q.delete();
        set_in();
        #1;
        check("mid_rst_tvalid", m_axis_tvalid, 0);
        check("mid_rst_tlast", m_axis_tlast, 0);
        check("mid_rst_tdata", m_axis_tdata, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_tready", s_axis_tready, 0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        clear_obs();
        pkt_len = 16'd3;
        m_axis_tready = 1'b1;
        load(32'hA1, 6);
        run_out("post", 6, 40, -1, 16'd0);
        check_beats("post", 6, 32'hA1, 32'b10_0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_stream_packetizer.md
SAMPLE_STREAM_PACKETIZER -- requirements
Module: sample_stream_packetizer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width in bits.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, buffer entries; power of two, minimum 4.
REQ-003 SHALL have parameter PKT_LEN_W, default 16, width of the packet-length input.
REQ-004 SHALL have port ACLK, input, 1, sole clock; all logic on its rising edge.
REQ-005 SHALL have port ARESET, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port enable, input, 1, gates acceptance of input samples.
REQ-007 SHALL have port pkt_len, input, PKT_LEN_W, beats per output packet.
REQ-008 SHALL have ports s_axis_tdata (input, DATA_W), s_axis_tvalid (input, 1) and s_axis_tready (output, 1), the sample stream from the sampler.
REQ-009 SHALL have ports m_axis_tdata (output, DATA_W), m_axis_tvalid (output, 1), m_axis_tready (input, 1) and m_axis_tlast (output, 1), the packetized output stream.
REQ-010 SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1, current occupancy.
REQ-011 SHALL have port drop_cnt, output, 16, dropped-sample count; present only with SAMPLE_DROP_EN.

Function
REQ-012 SHALL define a transfer on either stream as a cycle with tvalid=1 and tready=1.
REQ-013 SHALL write each accepted input sample into a first-word-fall-through FIFO of FIFO_DEPTH entries, preserving order.
REQ-014 SHALL present a sample accepted in cycle N, into an empty FIFO, on m_axis with m_axis_tvalid=1 in cycle N+1; there is no combinational path from s_axis to m_axis.
REQ-015 SHALL assert m_axis_tvalid whenever fifo_level>0 and hold m_axis_tdata and m_axis_tlast stable until the output transfer completes.
REQ-016 SHALL count output transfers in beat_cnt, and latch pkt_len into cur_len whenever beat_cnt=0.
REQ-017 SHALL assert m_axis_tlast when beat_cnt = cur_len-1, and clear beat_cnt to 0 on that transfer.
REQ-018 SHALL treat cur_len values 0 and 1 as one beat per packet, with tlast on every beat.
REQ-019 SHALL ignore pkt_len changes mid-packet; the new value takes effect at the next packet start.
REQ-020 SHALL update fifo_level as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL drive s_axis_tready=0 while enable=0; the FIFO SHALL continue draining to m_axis while enable=0.
REQ-022 SHALL hold beat_cnt when enable drops mid-packet; the packet resumes with the next samples after re-enable.
REQ-023 SHALL wrap read and write pointers modulo FIFO_DEPTH, with full = (level = FIFO_DEPTH).

Reset
REQ-024 SHALL, while ARESET=1, force the FIFO empty and drive fifo_level=0, beat_cnt=0, cur_len=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0 and drop_cnt=0.
REQ-025 SHALL, on reset asserted mid-packet, discard all buffered data; the first packet after release starts at beat 0.
REQ-026 SHALL allow s_axis_tready to rise no earlier than the first ACLK edge after ARESET deasserts.

Configuration
REQ-027 SHALL, with macro SAMPLE_DROP_EN defined, drive s_axis_tready=enable, so the sampler is never stalled.
REQ-028 SHALL, with SAMPLE_DROP_EN defined, discard a sample offered while full (even with a simultaneous pop) and increment drop_cnt, which saturates at 16'hFFFF.
REQ-029 SHALL, without SAMPLE_DROP_EN, drive s_axis_tready = enable & ~full (backpressure), drop no samples and omit the drop_cnt port.

Verification
REQ-030 SHALL cover: pkt_len=4, 8 samples 0x1..0x8, m_axis_tready=1 -> tlast on 0x4 and 0x8 only; first output one cycle after first input.
REQ-031 SHALL cover: pkt_len=0, then pkt_len=1, 3 samples each -> tlast on every beat.
REQ-032 SHALL cover: m_axis_tready=0 with 20 samples offered, SAMPLE_DROP_EN defined -> fifo_level=16, drop_cnt=4, outputs 0x1..0x10 in order.
REQ-033 SHALL cover: same stimulus without SAMPLE_DROP_EN -> s_axis_tready=0 at level 16, no loss, all 20 samples delivered after m_axis_tready rises.
REQ-034 SHALL cover: pkt_len changed 4 to 2 after beat 2 of a packet -> current packet ends at beat 4, following packets are 2 beats.
REQ-035 SHALL cover: ARESET pulsed with 5 samples buffered mid-packet -> all outputs at reset values; the next packet's tlast occurs at beat pkt_len.
